led_count_uart_tx: RTL
======================

# led_count_uart_tx

Serial transmitter for the remote LED counter. It watches the 8-bit count that drives the board LEDs and sends every new value to the remote host as one UART 8N1 frame, so the host sees the count the LEDs show. It sits beside the LED counter, takes its 8-bit output directly, and drives the board's UART TX pin.

## Interface
- CLK_FREQ, 25_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division) must be ≥ 2.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- count_in  in  8  current LED count from the counter, sampled every cycle.
- send_now  in  1  one-cycle request to transmit the current count even if it has not changed.
- tx  out  1  UART line, idles high.
- busy  out  1  high while a frame is in progress (start, data or stop bit).
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Internal registers:
  - last_sent[7:0]: value of the last frame, reset 0.
  - shreg[7:0]: data shift register.
  - bit_timer: counts 0..CLKS_PER_BIT-1.
  - bit_idx[2:0]: data bit index.
  - force_pend: latched send_now request.
- Frame-start trigger, evaluated in IDLE: (count_in != last_sent) OR force_pend OR send_now.
- FSM states:
  - IDLE: tx=1, busy=0. On trigger: shreg←count_in, last_sent←count_in, force_pend←0, bit_timer←0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then bit_idx←0 and go to DATA.
  - DATA: tx=shreg[0], sending LSB first, each bit for CLKS_PER_BIT cycles. At the end of each bit, shift shreg right. After bit_idx=7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with frame_done=1 for that one cycle.
- Send requests while busy:
  - send_now asserted outside IDLE sets force_pend.
  - Multiple send_now pulses during one frame collapse into one extra frame.
- count_in changes during a frame are not queued. Only the value present in the first IDLE cycle after the frame is compared and sent, so intermediate values are dropped.
- When count_in equals last_sent and no request is pending, the block stays in IDLE indefinitely.
- Because last_sent resets to 0, a nonzero count_in after reset triggers a frame. count_in=0 after reset does not.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, state=IDLE, last_sent=0, force_pend=0, bit_timer=0, bit_idx=0.
- Reset asserted mid-frame aborts the frame. tx=1 and busy=0 from the first clock edge with rst=1, and no frame_done is produced.
- Trigger latency: trigger true in IDLE at edge N means tx falls and busy rises after edge N, in cycle N+1.
- Frame length is 10·CLKS_PER_BIT cycles:
  - start bit in cycles N+1 .. N+CLKS_PER_BIT;
  - data bit k starts at N+1+(k+1)·CLKS_PER_BIT;
  - stop bit ends at cycle N+10·CLKS_PER_BIT.
- frame_done is high in cycle N+10·CLKS_PER_BIT+1, the first IDLE cycle with busy=0. This is also the cycle in which the next trigger is evaluated.
- Back-to-back frames: at least one IDLE cycle with tx=1 separates consecutive frames.
- send_now and a count change in the same IDLE cycle produce one frame, not two.
- send_now in the same cycle that STOP finishes (the transition to IDLE) sets force_pend, so exactly one further frame follows.

## Test plan
Bench parameters: CLK_FREQ=10, BAUD_RATE=2, so CLKS_PER_BIT=5 and one frame lasts 50 cycles.

1. Hold rst=1 for 3 cycles, release, keep count_in=0 for 100 cycles -> tx=1, busy=0 and frame_done=0 throughout.
2. Step count_in from 0x00 to 0xA5 at edge N -> tx=0 in cycles N+1..N+5, then data bits 1,0,1,0,0,1,0,1 at 5 cycles each, stop=1 for 5 cycles. frame_done pulses at N+51 and busy falls at N+51. The decoded byte is 0xA5.
3. Set count_in=0x01, then 0x02 and 0x03 during that frame -> exactly two frames, carrying 0x01 and 0x03. The second start bit begins at the cycle after frame_done.
4. In IDLE with count_in=last_sent=0x03, pulse send_now -> one frame carrying 0x03. Pulse send_now twice during that frame -> exactly one more 0x03 frame, then idle.
5. Assert rst during data bit 4 of a 0x5A frame -> tx=1 and busy=0 the next cycle, no frame_done. After release with count_in=0x5A, a fresh full 0x5A frame is sent, because last_sent was reset to 0.
6. Pulse send_now in the same cycle count_in changes to 0x10 -> exactly one frame carrying 0x10.

Source files
------------

// File: rtl/led_count_uart_tx.sv
// led_count_uart_tx: transmits each new LED count (or a forced resend) as one UART 8N1 frame.
module led_count_uart_tx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  input  logic       send_now,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int TW  = $clog2(CPB);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_nx;
  logic [7:0]    last_sent, shreg;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic          force_pend, trigger, bit_end;
  assign trigger = (count_in != last_sent) || force_pend || send_now;
  assign bit_end = bit_timer == TW'(CPB - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_sent  <= '0;
      shreg      <= '0;
      bit_timer  <= '0;
      bit_idx    <= '0;
      force_pend <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= state == STOP && bit_end;
      bit_timer  <= (state == IDLE || bit_end) ? '0 : bit_timer + 1'b1;
      // a request arriving while busy (including the last STOP cycle) yields one extra frame
      if (state == IDLE && trigger) begin
        shreg      <= count_in;
        last_sent  <= count_in;
        force_pend <= 1'b0;
      end else if (state != IDLE && send_now)
        force_pend <= 1'b1;
      if (state == START && bit_end)
        bit_idx <= '0;
      if (state == DATA && bit_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (trigger ? START : IDLE) :
               !bit_end       ? state :
               state == START ? DATA :
               state == DATA  ? (bit_idx == 3'd7 ? STOP : DATA) : IDLE;
  end
  always_comb begin
    tx   = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    busy = state != IDLE;
  end
endmodule
